// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_NOP0  = 3'b110,
    MD_NOP1  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Sign handling around the unsigned iterative core: magnitudes on entry,
// two's-complement correction of product or quotient/remainder at the end.
module muldiv_unit_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [WIDTH-1:0]   abs_a_c,
  output logic [WIDTH-1:0]   abs_b_c,
  output logic               neg_a_c,
  output logic               neg_b_c,
  input  logic               is_div,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quot,
  input  logic [WIDTH-1:0]   rem,
  output logic [WIDTH-1:0]   hi_c,
  output logic [WIDTH-1:0]   lo_c
);

  logic [2*WIDTH-1:0] prod_fix;

  // Operand magnitudes and signs (signs forced positive for unsigned ops)
  always_comb begin
    neg_a_c = is_signed & a[WIDTH-1];
    neg_b_c = is_signed & b[WIDTH-1];
    abs_a_c = neg_a_c ? WIDTH'(WIDTH'(0) - a) : a;
    abs_b_c = neg_b_c ? WIDTH'(WIDTH'(0) - b) : b;
  end

  // Result sign correction selected by op class
  always_comb begin
    prod_fix = neg_res ? (2*WIDTH)'((2*WIDTH)'(0) - prod) : prod;
    if (is_div) begin
      lo_c = neg_res ? WIDTH'(WIDTH'(0) - quot) : quot;
      hi_c = neg_rem ? WIDTH'(WIDTH'(0) - rem) : rem;
    end else begin
      hi_c = prod_fix[2*WIDTH-1:WIDTH];
      lo_c = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: 32 shift-add or restoring
// iterations, one sign-fix cycle, plus single-cycle MTHI/MTLO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             is_signed_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  logic             neg_a_c, neg_b_c;
  logic [WIDTH-1:0] hi_fix_c, lo_fix_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_shift_c;
  logic             div_nb_c;

  assign is_signed_c = (op == MD_MULT) || (op == MD_DIV);

  muldiv_unit_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a         (a),
    .b         (b),
    .is_signed (is_signed_c),
    .abs_a_c   (abs_a_c),
    .abs_b_c   (abs_b_c),
    .neg_a_c   (neg_a_c),
    .neg_b_c   (neg_b_c),
    .is_div    (is_div_q),
    .neg_res   (neg_res_q),
    .neg_rem   (neg_rem_q),
    .prod      ({acc_q, mq_q}),
    .quot      (mq_q),
    .rem       (acc_q),
    .hi_c      (hi_fix_c),
    .lo_c      (lo_fix_c)
  );

  // Next-state, iteration datapath and result write-back
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    mul_sum_c   = mq_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
    div_shift_c = {acc_q, mq_q[WIDTH-1]};
    div_nb_c    = (div_shift_c >= {1'b0, opnd_q});

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op_e'(op))
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_d  = op[1];
              acc_d     = '0;
              mq_d      = op[1] ? abs_a_c : abs_b_c;
              opnd_d    = op[1] ? abs_b_c : abs_a_c;
              // divide-by-zero keeps quotient all-ones and remainder == a
              neg_res_d = (neg_a_c ^ neg_b_c) & ~(op[1] && (b == '0));
              neg_rem_d = neg_a_c;
              cnt_d     = '0;
              state_d   = ST_CALC;
            end
            MD_MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            MD_MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          acc_d = div_nb_c ? WIDTH'(div_shift_c - {1'b0, opnd_q}) : div_shift_c[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], div_nb_c};
        end else begin
          acc_d = mul_sum_c[WIDTH:1];
          mq_d  = {mul_sum_c[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        hi_d    = hi_fix_c;
        lo_d    = lo_fix_c;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // squash wins over start and over a pending write-back
    if (flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} queued at issue,
// popped and compared by a monitor on every done pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on each done pulse; hi/lo must hold while busy
  always @(negedge clk) begin
    if (busy === 1'b1 && rst === 1'b0) begin
      check32("hold_hi_while_busy", hi, prev_hi);
      check32("hold_lo_while_busy", lo, prev_lo);
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check32("done_hi", hi, e[63:32]);
        check32("done_lo", lo, e[31:0]);
        check32("done_busy_low", 32'(busy), 32'd0);
      end
    end
    prev_hi = hi;
    prev_lo = lo;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int n;
    exp_q.push_back({eh, el});
    m_hi = eh;
    m_lo = el;
    issue(o, x, y);
    wait_idle(n);
    check32({name, "_latency"}, 32'(n), 32'd33);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MD_NOP0; a = '0; b = '0;
    tick(); tick();
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_done", 32'(done), 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    rst = 1'b0;
    tick();

    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg1x2", MD_MULT, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mult_min_sq", MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("mult_m3x5", MD_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7_2", MD_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
    run_op("div_7_m2", MD_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100_7", MD_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    run_op("div_5_0", MD_DIV, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
    run_op("div_m5_0", MD_DIV, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("divu_max_0", MD_DIVU, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_min_m1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI then MTLO back to back, never busy
    op = MD_MTHI; a = 32'h00001234; start = 1'b1;
    exp_q.push_back({32'h00001234, m_lo});
    tick();
    check32("mthi_busy", 32'(busy), 32'd0);
    op = MD_MTLO; a = 32'h00005678;
    exp_q.push_back({32'h00001234, 32'h00005678});
    tick();
    start = 1'b0;
    check32("mtlo_busy", 32'(busy), 32'd0);
    m_hi = 32'h00001234; m_lo = 32'h00005678;
    tick();
    check32("mt_hi", hi, 32'h00001234);
    check32("mt_lo", lo, 32'h00005678);

    // start during an op is dropped
    exp_q.push_back({32'h00000000, 32'h0000000C});
    m_hi = 32'h0; m_lo = 32'h0000000C;
    issue(MD_MULTU, 32'd3, 32'd4);
    repeat (4) tick();
    issue(MD_MTHI, 32'hDEADBEEF, 32'd0);
    wait_idle(n);
    tick(); tick();
    check32("ignored_start_hi", hi, 32'h00000000);

    // flush mid-divide: no done, hi/lo unchanged
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check32("flush_busy", 32'(busy), 32'd0);
    check32("flush_hi", hi, m_hi);
    check32("flush_lo", lo, m_lo);
    repeat (40) tick();
    check32("flush_hi_late", hi, m_hi);
    check32("flush_lo_late", lo, m_lo);

    // flush beats start in the same cycle
    flush = 1'b1; op = MD_MTHI; a = 32'h0000FFFF; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    tick();
    check32("flush_vs_start_hi", hi, m_hi);
    check32("flush_vs_start_busy", 32'(busy), 32'd0);

    // reset mid-multiply clears everything
    issue(MD_MULT, 32'h00000123, 32'h00000456);
    repeat (18) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check32("rst_mid_busy", 32'(busy), 32'd0);
    check32("rst_mid_hi", hi, 32'd0);
    check32("rst_mid_lo", lo, 32'd0);
    repeat (40) tick();
    check32("rst_mid_hi_late", hi, 32'd0);

    check32("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
